// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 port arbiter: line type, FSM states, requester ids
// and a saturating-increment helper used by the performance counters.
package l2_arbiter_pkg;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } lc3b_arb_state;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } lc3b_arb_id;

  // Increment by one when enabled, sticking at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic en);
    if (en && (value != 16'hFFFF)) begin
      return value + 16'd1;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundle of the icache, dcache and L2 line ports around the arbiter.
// slave  : the arbiter's view (requests in, L2 requests out).
// master : the surrounding caches' and L2's view.
interface l2_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
);
  import l2_arbiter_pkg::*;

  logic              i_read;
  logic              i_write;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_wdata;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  modport slave (
    input  i_read, i_write, i_address, i_wdata,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    output l2_read, l2_write, l2_address, l2_wdata,
    input  l2_rdata, l2_resp
  );

  modport master (
    output i_read, i_write, i_address, i_wdata,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  l2_read, l2_write, l2_address, l2_wdata,
    output l2_rdata, l2_resp
  );

endinterface

// File: rtl/l2_arbiter_chk.sv
// Protocol checker for the arbiter's requesters: read and write together is illegal.
module l2_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic i_read,
  input logic i_write,
  input logic d_read,
  input logic d_write
);

  a_i_rw_excl: assert property (@(posedge clk) disable iff (reset) !(i_read && i_write));
  a_d_rw_excl: assert property (@(posedge clk) disable iff (reset) !(d_read && d_write));

endmodule

// File: rtl/l2_arbiter_perf.sv
// Saturating event counters for the L2 arbiter (only built with L2_ARB_PERF_EN).
module l2_arbiter_perf
  import l2_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_done,
  input  logic        d_done,
  input  logic        stall,
  output logic [15:0] perf_i_grants,
  output logic [15:0] perf_d_grants,
  output logic [15:0] perf_stall
);

  // Count completions per requester and cycles spent waiting behind the other.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_i_grants <= 16'd0;
      perf_d_grants <= 16'd0;
      perf_stall    <= 16'd0;
    end else begin
      perf_i_grants <= sat_inc16(perf_i_grants, i_done);
      perf_d_grants <= sat_inc16(perf_d_grants, d_done);
      perf_stall    <= sat_inc16(perf_stall, stall);
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the unified L2 port between icache and dcache miss paths.
// One line transaction at a time, round-robin on simultaneous requests, and a
// mandatory idle cycle after every completion. Optional counters are enabled
// with the L2_ARB_PERF_EN macro.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic         clk,
  input  logic         reset,
  l2_arbiter_if.slave  bus
`ifdef L2_ARB_PERF_EN
  ,
  output logic [15:0]  perf_i_grants,
  output logic [15:0]  perf_d_grants,
  output logic [15:0]  perf_stall
`endif
);

  lc3b_arb_state     state_r;
  lc3b_arb_state     state_nxt_s;
  lc3b_arb_id        last_grant_r;
  lc3b_arb_id        last_grant_nxt_s;
  logic [LINE_W-1:0] i_rdata_r;
  logic [LINE_W-1:0] d_rdata_r;

  logic              i_req_s;
  logic              d_req_s;
  logic              i_done_s;
  logic              d_done_s;
  logic              sel_read_s;
  logic              sel_write_s;
  logic [ADDR_W-1:0] sel_address_s;
  logic [LINE_W-1:0] sel_wdata_s;

  assign i_req_s = bus.i_read | bus.i_write;
  assign d_req_s = bus.d_read | bus.d_write;

  // State, grant history and returned-line holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ARB_IDLE;
      last_grant_r <= ARB_D;
      i_rdata_r    <= '0;
      d_rdata_r    <= '0;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      if (i_done_s) begin
        i_rdata_r <= bus.l2_rdata;
      end else begin
        i_rdata_r <= i_rdata_r;
      end
      if (d_done_s) begin
        d_rdata_r <= bus.l2_rdata;
      end else begin
        d_rdata_r <= d_rdata_r;
      end
    end
  end

  // Arbitration decision in IDLE; L2 port steering and completion in SERVE.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    i_done_s         = 1'b0;
    d_done_s         = 1'b0;
    sel_read_s       = 1'b0;
    sel_write_s      = 1'b0;
    sel_address_s    = '0;
    sel_wdata_s      = '0;
    case (state_r)
      ARB_IDLE: begin
        // Requester inputs only feed the registered decision here, never l2_*.
        if (i_req_s && d_req_s) begin
          if (last_grant_r == ARB_I) begin
            state_nxt_s = ARB_SERVE_D;
          end else begin
            state_nxt_s = ARB_SERVE_I;
          end
        end else if (i_req_s) begin
          state_nxt_s = ARB_SERVE_I;
        end else if (d_req_s) begin
          state_nxt_s = ARB_SERVE_D;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_SERVE_I: begin
        sel_read_s    = bus.i_read;
        sel_write_s   = bus.i_write;
        sel_address_s = bus.i_address;
        sel_wdata_s   = bus.i_wdata;
        if (bus.l2_resp) begin
          i_done_s         = 1'b1;
          last_grant_nxt_s = ARB_I;
          state_nxt_s      = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_SERVE_I;
        end
      end
      ARB_SERVE_D: begin
        sel_read_s    = bus.d_read;
        sel_write_s   = bus.d_write;
        sel_address_s = bus.d_address;
        sel_wdata_s   = bus.d_wdata;
        if (bus.l2_resp) begin
          d_done_s         = 1'b1;
          last_grant_nxt_s = ARB_D;
          state_nxt_s      = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_SERVE_D;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  assign bus.l2_read    = sel_read_s;
  assign bus.l2_write   = sel_write_s;
  assign bus.l2_address = sel_address_s;
  assign bus.l2_wdata   = sel_wdata_s;

  // The completing line is passed straight through, then held in the register.
  assign bus.i_resp  = i_done_s;
  assign bus.d_resp  = d_done_s;
  assign bus.i_rdata = i_done_s ? bus.l2_rdata : i_rdata_r;
  assign bus.d_rdata = d_done_s ? bus.l2_rdata : d_rdata_r;

  l2_arbiter_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .i_read  (bus.i_read),
    .i_write (bus.i_write),
    .d_read  (bus.d_read),
    .d_write (bus.d_write)
  );

`ifdef L2_ARB_PERF_EN
  logic stall_s;

  // A stall cycle is one where a requester waits while the port serves the other.
  assign stall_s = ((state_r == ARB_SERVE_I) && d_req_s) ||
                   ((state_r == ARB_SERVE_D) && i_req_s);

  l2_arbiter_perf u_perf (
    .clk           (clk),
    .reset         (reset),
    .i_done        (i_done_s),
    .d_done        (d_done_s),
    .stall         (stall_s),
    .perf_i_grants (perf_i_grants),
    .perf_d_grants (perf_d_grants),
    .perf_stall    (perf_stall)
  );
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus randomized
// traffic, all compared every cycle against a port-ownership model.
// Build with L2_ARB_PERF_EN to also exercise the performance counters.
module tb_l2_arbiter;
  import l2_arbiter_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned LW = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  l2_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

`ifdef L2_ARB_PERF_EN
  logic [15:0] perf_i_grants, perf_d_grants, perf_stall;
`endif

  l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef L2_ARB_PERF_EN
    ,
    .perf_i_grants (perf_i_grants),
    .perf_d_grants (perf_d_grants),
    .perf_stall    (perf_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  // requester drivers
  bit i_act = 0, i_rd = 0, i_wr = 0, got_i = 0;
  bit d_act = 0, d_rd = 0, d_wr = 0, got_d = 0;
  logic [15:0] i_addr = 16'h0, d_addr = 16'h0;
  lc3b_line i_wd = '0, d_wd = '0;
  bit rand_on = 0;
  bit rst_drv = 1;

  // L2 responder
  int l2_cnt = 0, l2_lat = 1, lat_fixed = 1;
  bit lat_rand = 0, spur_en = 0, force_spur = 0, rdata_fixed = 0;
  lc3b_line fixed_rdata = '0;

  // reference model: who owns the port, who went last, what each cache holds
  bit model_valid = 0;
  int m_owner = 0;   // 0 none, 1 icache, 2 dcache
  int m_last = 2;
  lc3b_line m_ir = '0, m_dr = '0;
  logic [15:0] m_ig = 16'd0, m_dg = 16'd0, m_st = 16'd0;

  // per-step history for directed literal checks
  logic h_l2r[64], h_l2w[64], h_iresp[64], h_dresp[64];
  logic [15:0] h_addr[64];
  lc3b_line h_wd[64], h_irdata[64], h_drdata[64];
  int h = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic lc3b_line rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic req_i(input bit rd, input bit wr, input logic [15:0] a, input lc3b_line w);
    i_act = 1; i_rd = rd; i_wr = wr; i_addr = a; i_wd = w; got_i = 0;
  endtask

  task automatic req_d(input bit rd, input bit wr, input logic [15:0] a, input lc3b_line w);
    d_act = 1; d_rd = rd; d_wr = wr; d_addr = a; d_wd = w; got_d = 0;
  endtask

  task automatic set_lat(input int n);
    lat_fixed = n; l2_lat = n; l2_cnt = 0;
  endtask

  // Compare every DUT output with the model, then advance the model by one edge.
  task automatic check_cycle();
    bit ireq, dreq;
    logic exp_r, exp_w, exp_ir, exp_dr;
    logic [15:0] exp_a;
    lc3b_line exp_wd, exp_ird, exp_drd;
    ireq = bus.i_read | bus.i_write;
    dreq = bus.d_read | bus.d_write;
    exp_r = 0; exp_w = 0; exp_a = '0; exp_wd = '0; exp_ir = 0; exp_dr = 0;
    exp_ird = m_ir; exp_drd = m_dr;
    if (m_owner == 1) begin
      exp_r = bus.i_read; exp_w = bus.i_write; exp_a = bus.i_address; exp_wd = bus.i_wdata;
      if (bus.l2_resp) begin exp_ir = 1; exp_ird = bus.l2_rdata; end
    end else if (m_owner == 2) begin
      exp_r = bus.d_read; exp_w = bus.d_write; exp_a = bus.d_address; exp_wd = bus.d_wdata;
      if (bus.l2_resp) begin exp_dr = 1; exp_drd = bus.l2_rdata; end
    end
    if (model_valid) begin
      chk("l2_read", bus.l2_read, exp_r);
      chk("l2_write", bus.l2_write, exp_w);
      chk("l2_address", bus.l2_address, exp_a);
      chk("l2_wdata", bus.l2_wdata, exp_wd);
      chk("i_resp", bus.i_resp, exp_ir);
      chk("d_resp", bus.d_resp, exp_dr);
      chk("i_rdata", bus.i_rdata, exp_ird);
      chk("d_rdata", bus.d_rdata, exp_drd);
`ifdef L2_ARB_PERF_EN
      chk("perf_i_grants", perf_i_grants, m_ig);
      chk("perf_d_grants", perf_d_grants, m_dg);
      chk("perf_stall", perf_stall, m_st);
`endif
    end
    if (h < 64) begin
      h_l2r[h] = bus.l2_read; h_l2w[h] = bus.l2_write; h_addr[h] = bus.l2_address;
      h_wd[h] = bus.l2_wdata; h_iresp[h] = bus.i_resp; h_dresp[h] = bus.d_resp;
      h_irdata[h] = bus.i_rdata; h_drdata[h] = bus.d_rdata;
      h++;
    end
    got_i = bus.i_resp;
    got_d = bus.d_resp;
    if (reset) begin
      model_valid = 1; m_owner = 0; m_last = 2; m_ir = '0; m_dr = '0;
      m_ig = 16'd0; m_dg = 16'd0; m_st = 16'd0;
    end else begin
      if (((m_owner == 1) && dreq) || ((m_owner == 2) && ireq))
        if (m_st != 16'hFFFF) m_st++;
      if (m_owner == 0) begin
        if (ireq && dreq) m_owner = (m_last == 1) ? 2 : 1;
        else if (ireq) m_owner = 1;
        else if (dreq) m_owner = 2;
      end else if (bus.l2_resp) begin
        if (m_owner == 1) begin m_ir = bus.l2_rdata; if (m_ig != 16'hFFFF) m_ig++; end
        else begin m_dr = bus.l2_rdata; if (m_dg != 16'hFFFF) m_dg++; end
        m_last = m_owner;
        m_owner = 0;
      end
    end
  endtask

  // One clock: drive requesters, then the L2 responder, then check at negedge.
  task automatic step();
    bit resp;
    @(posedge clk);
    #1;
    reset = rst_drv;
    if (i_act && got_i) i_act = 0;
    if (d_act && got_d) d_act = 0;
    if (rand_on) begin
      if (!i_act && ($urandom_range(0, 2) == 0)) begin
        if ($urandom_range(0, 7) == 0) req_i(0, 1, 16'($urandom()), rnd_line());
        else req_i(1, 0, 16'($urandom()), rnd_line());
      end
      if (!d_act && ($urandom_range(0, 2) == 0)) begin
        if ($urandom_range(0, 1) == 0) req_d(0, 1, 16'($urandom()), rnd_line());
        else req_d(1, 0, 16'($urandom()), rnd_line());
      end
    end
    bus.i_read = i_act & i_rd; bus.i_write = i_act & i_wr;
    bus.i_address = i_addr; bus.i_wdata = i_wd;
    bus.d_read = d_act & d_rd; bus.d_write = d_act & d_wr;
    bus.d_address = d_addr; bus.d_wdata = d_wd;
    #1;
    resp = 0;
    if (bus.l2_read | bus.l2_write) begin
      if (l2_cnt >= l2_lat) begin
        resp = 1;
        l2_cnt = 0;
        l2_lat = lat_rand ? int'($urandom_range(0, 4)) : lat_fixed;
      end else begin
        l2_cnt++;
      end
    end else begin
      l2_cnt = 0;
      resp = force_spur | (spur_en && ($urandom_range(0, 15) == 0));
    end
    bus.l2_resp = resp;
    bus.l2_rdata = (resp && rdata_fixed) ? fixed_rdata : rnd_line();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst_drv = 1; step(); step(); rst_drv = 0; step();
  endtask

  initial begin : main
    lc3b_line dead;
    int cnt_i, cnt_d;
    dead = {8{16'hDEAD}};
    bus.i_read = 0; bus.i_write = 0; bus.i_address = '0; bus.i_wdata = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
    bus.l2_resp = 0; bus.l2_rdata = '0;

    // reset state
    do_reset();
    chk("rst_l2_read", h_l2r[h-1], 1'b0);
    chk("rst_i_rdata", h_irdata[h-1], 128'h0);
    chk("rst_d_rdata", h_drdata[h-1], 128'h0);

    // single icache read, L2 latency 3
    set_lat(3); rdata_fixed = 1; fixed_rdata = {16{8'hA5}};
    h = 0; req_i(1, 0, 16'h0040, '0);
    steps(8);
    chk("t1_l2_read_idle", h_l2r[0], 1'b0);
    chk("t1_l2_read_lat1", h_l2r[1], 1'b1);
    chk("t1_l2_address", h_addr[1], 16'h0040);
    chk("t1_i_resp_early", h_iresp[3], 1'b0);
    chk("t1_i_resp", h_iresp[4], 1'b1);
    chk("t1_i_rdata", h_irdata[4], {16{8'hA5}});
    cnt_i = 0; cnt_d = 0;
    for (int k = 0; k < 8; k++) begin cnt_i += int'(h_iresp[k]); cnt_d += int'(h_dresp[k]); end
    chk("t1_i_resp_count", cnt_i, 1);
    chk("t1_d_resp_count", cnt_d, 0);
    rdata_fixed = 0;

    // first tie after reset goes to icache, then an idle cycle, then dcache
    do_reset(); set_lat(1);
    h = 0; req_i(1, 0, 16'h0100, rnd_line()); req_d(1, 0, 16'h0200, rnd_line());
    steps(8);
    chk("t2_first_addr", h_addr[1], 16'h0100);
    chk("t2_i_resp", h_iresp[2], 1'b1);
    chk("t2_idle_gap", h_l2r[3], 1'b0);
    chk("t2_d_start", h_l2r[4], 1'b1);
    chk("t2_d_addr", h_addr[4], 16'h0200);
    chk("t2_d_resp", h_dresp[5], 1'b1);

    // after a lone icache completion, the next tie goes to dcache
    req_i(1, 0, 16'h0280, rnd_line()); steps(6);
    h = 0; req_i(1, 0, 16'h0300, rnd_line()); req_d(1, 0, 16'h0400, rnd_line());
    steps(8);
    chk("t2b_first_addr", h_addr[1], 16'h0400);
    chk("t2b_d_resp", h_dresp[2], 1'b1);
    chk("t2b_i_resp", h_iresp[5], 1'b1);

    // dcache write-back while icache read is held (last grant was icache)
    h = 0; req_i(1, 0, 16'h0500, rnd_line()); req_d(0, 1, 16'h1230, dead);
    steps(8);
    chk("t3_l2_write", h_l2w[1], 1'b1);
    chk("t3_l2_read", h_l2r[1], 1'b0);
    chk("t3_l2_wdata", h_wd[1], dead);
    chk("t3_l2_address", h_addr[1], 16'h1230);
    chk("t3_i_waits", h_iresp[2], 1'b0);
    chk("t3_d_resp", h_dresp[2], 1'b1);
    chk("t3_i_resp", h_iresp[5], 1'b1);

    // reset two cycles into SERVE_D, request held, then completes normally
    set_lat(10);
    h = 0; req_d(1, 0, 16'h0600, rnd_line());
    steps(3);
    rst_drv = 1; step(); rst_drv = 0;
    set_lat(2);
    steps(6);
    chk("t4_serving", h_l2r[2], 1'b1);
    chk("t4_abandon", h_l2r[4], 1'b0);
    cnt_d = 0;
    for (int k = 0; k < 5; k++) cnt_d += int'(h_dresp[k]);
    chk("t4_no_d_resp", cnt_d, 0);
    chk("t4_redo_d_resp", h_dresp[7], 1'b1);

    // spurious l2_resp while idle
    steps(2);
    h = 0; force_spur = 1; step(); force_spur = 0;
    step();
    req_i(1, 0, 16'h0700, rnd_line()); steps(2);
    chk("t5_i_resp", h_iresp[0], 1'b0);
    chk("t5_d_resp", h_dresp[0], 1'b0);
    chk("t5_still_idle", h_l2r[1], 1'b0);
    chk("t5_req_idle", h_l2r[2], 1'b0);
    chk("t5_req_serve", h_l2r[3], 1'b1);
    steps(6);

`ifdef L2_ARB_PERF_EN
    // 3 icache and 2 dcache completions with 4 waiting cycles
    do_reset(); set_lat(1);
    chk("perf_i_reset", perf_i_grants, 16'd0);
    req_i(1, 0, 16'h0800, rnd_line()); req_d(1, 0, 16'h0900, rnd_line()); steps(8);
    req_i(1, 0, 16'h0A00, rnd_line()); req_d(0, 1, 16'h0B00, rnd_line()); steps(8);
    req_i(1, 0, 16'h0C00, rnd_line()); steps(6);
    chk("perf_i_grants_3", perf_i_grants, 16'd3);
    chk("perf_d_grants_2", perf_d_grants, 16'd2);
    chk("perf_stall_4", perf_stall, 16'd4);
`endif

    // randomized traffic with random L2 latency and spurious responses
    do_reset();
    lat_rand = 1; spur_en = 1; rand_on = 1;
    steps(3000);
    rand_on = 0; spur_en = 0;
    steps(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares the single unified L2 cache port between the instruction-cache miss path and the data-cache miss path.
- Serves one line transaction at a time, read or write-back, with round-robin priority when both requesters ask in the same cycle.
- Sits between the L1 icache/dcache miss interfaces and the L2 cache.
- Uses the same level-request / single-cycle-resp handshake as the CPU memory ports.

Parameters:
- ADDR_W, 16, byte address width.
- LINE_W, 128, cache line width (8 lc3b words).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_read  in  1  icache line read request (level)
- i_write  in  1  icache line write request (level; normally 0)
- i_address  in  ADDR_W  icache line address
- i_wdata  in  LINE_W  icache write line
- i_rdata  out  LINE_W  read line to icache
- i_resp  out  1  icache completion pulse
- d_read  in  1  dcache line read request
- d_write  in  1  dcache write-back request
- d_address  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  dcache write-back line
- d_rdata  out  LINE_W  read line to dcache
- d_resp  out  1  dcache completion pulse
- l2_read  out  1  L2 read request
- l2_write  out  1  L2 write request
- l2_address  out  ADDR_W  L2 address
- l2_wdata  out  LINE_W  L2 write line
- l2_rdata  in  LINE_W  L2 read line
- l2_resp  in  1  L2 completion pulse

Behaviour:
- FSM states:
  - IDLE, SERVE_I, SERVE_D.
  - Register last_grant (I/D).
- Reset (sync, active-high):
  - State to IDLE, last_grant to D.
  - All outputs 0 from the next edge, including i_rdata and d_rdata.
- IDLE:
  - l2_read/l2_write=0.
  - If exactly one requester has read|write, go to its SERVE state.
  - If both request, grant the one not equal to last_grant (first tie after reset goes to I).
  - Decision is registered, so L2 request latency is 1 cycle after request assertion.
- SERVE_x:
  - l2_read, l2_write, l2_address, l2_wdata are driven combinationally from requester x.
  - The other requester is fully ignored.
- On l2_resp in SERVE_x:
  - x_resp=1 in the same cycle (combinational pass-through).
  - x_rdata=l2_rdata, held in an output register until the next x_resp.
  - last_grant<=x, next state IDLE.
- Mandatory idle cycle:
  - One IDLE cycle always follows each completion, so a requester can deassert before re-arbitration.
  - Back-to-back throughput is therefore at most one transaction per L2 latency plus 2 cycles.
- Non-granted requester:
  - resp stays 0; it waits with its request held.
  - Starvation bound is one transaction.
- Protocol rules on requesters:
  - Hold address/wdata/read/write stable until resp.
  - read and write together is illegal; simulation assertion fires, RTL forwards both unchanged.
- Request withdrawn mid-SERVE (protocol violation): the FSM stays in SERVE until l2_resp, then returns to IDLE normally.
- l2_resp seen in IDLE: ignored; no requester resp.
- Reset mid-transaction: the FSM abandons the transaction. L2 must accept a dropped request on reset.
- No combinational path from requester inputs to l2_* outputs in IDLE.

Optional Feature:
- Macro: L2_ARB_PERF_EN.
- Defined: adds outputs perf_i_grants[15:0], perf_d_grants[15:0] and perf_stall[15:0].
  - Grant counters increment on each completion for the respective requester.
  - perf_stall increments each cycle a requester is requesting and not being served.
  - All counters saturate at 16'hFFFF and clear on reset.
- Undefined: ports and logic are absent; arbitration behaviour is identical.

Decomposition:
- Add to lc3b_types:
  - lc3b_line (logic [127:0]).
  - enum lc3b_arb_state {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}.
  - enum lc3b_arb_id {ARB_I, ARB_D}.
- Sub-module l2_arbiter_perf holds the three saturating counters; it is instantiated only under L2_ARB_PERF_EN.

Test Plan:
- Reset, then i_read=1, i_address=16'h0040; L2 resps 3 cycles after l2_read rises with line 128'hA5.. -> l2_read rises 1 cycle after request, l2_address=0040, i_resp pulses 1 cycle with i_rdata=A5.., d_resp never asserts.
- Simultaneous first requests i_read@0100, d_read@0200 -> I served first, then 1 idle cycle, then D. On a second simultaneous pair, D is served first because last_grant=I.
- d_write=1, d_address=16'h1230, d_wdata=128'hDEAD.. while i_read is held -> l2_write=1 with l2_wdata=DEAD..; i_resp stays 0 until D completes, then I is served.
- reset asserted 2 cycles into SERVE_D -> next edge state IDLE, l2_read=0, d_resp never pulses; re-requesting D completes normally.
- Spurious l2_resp=1 in IDLE -> i_resp=d_resp=0, state stays IDLE.
- With L2_ARB_PERF_EN, 3 I and 2 D completions with 4 contention cycles -> perf_i_grants=3, perf_d_grants=2, perf_stall=4; a forced 16'hFFFF value holds at saturation.
